// File: rtl/alu_seq_core.sv
// alu_seq_core: WIDTH-bit multi-cycle ALU, shift-add MUL, optional restoring DIV.
// Define ALU_DIV_EN to turn op 0 into an unsigned divider (else op 0 = A+B).
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               res,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         select,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_dz
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    p;
  logic [WIDTH-1:0] a_r;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a_sub_b;
  logic [WIDTH-1:0] b_sub_a;
  logic [W2-1:0]    alu_res;
  logic             alu_carry;

  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;

  assign in_ready = (state == IDLE);

  assign sum     = {1'b0, A} + {1'b0, B};
  assign a_sub_b = A - B;
  assign b_sub_a = B - A;

  function automatic logic [W2-1:0] zx(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  // Single-cycle result from the live operands; used only on accept
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (select)
`ifdef ALU_DIV_EN
      4'd1: begin
`else
      4'd0, 4'd1: begin
`endif
        alu_res   = {{(WIDTH-1){1'b0}}, sum};
        alu_carry = sum[WIDTH];
      end
      4'd2: begin
        alu_res   = zx(a_sub_b);
        alu_carry = (A < B);
      end
      4'd3: begin
        alu_res   = zx(b_sub_a);
        alu_carry = (B < A);
      end
      4'd5:  alu_res = zx(A & B);
      4'd6:  alu_res = zx(A | B);
      4'd7:  alu_res = zx(A ^ B);
      4'd8:  alu_res = zx({1'b0, A[WIDTH-1:1]});
      4'd9:  alu_res = zx({A[WIDTH-2:0], 1'b0});
      4'd10: alu_res = zx({1'b0, B[WIDTH-1:1]});
      4'd11: alu_res = zx({B[WIDTH-2:0], 1'b0});
      4'd12: alu_res = zx({A[WIDTH-1], A[WIDTH-1:1]});
      4'd13: alu_res = zx({B[WIDTH-1], B[WIDTH-1:1]});
      4'd14: alu_res = {{(W2-1){1'b0}}, (A == B)};
      4'd15: alu_res = {{(W2-1){1'b0}}, (A > B)};
      default: alu_res = '0;
    endcase
  end

  // p = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, p[W2-1:WIDTH]} + {1'b0, (p[0] ? a_r : '0)};
  assign mul_next = {mul_sum, p[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  // p = {partial remainder, dividend shifting into quotient}
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   dv_t;
  logic             dv_ge;
  logic [WIDTH-1:0] dv_sub;
  logic [W2-1:0]    div_next;

  assign dv_t     = {p[W2-1:WIDTH], p[WIDTH-1]};
  assign dv_ge    = (dv_t >= {1'b0, b_r});
  assign dv_sub   = dv_t[WIDTH-1:0] - b_r;
  assign div_next = {(dv_ge ? dv_sub : dv_t[WIDTH-1:0]),
                     p[WIDTH-2:0], dv_ge};
`else
  assign flag_dz = 1'b0;
`endif

  // Control FSM with registered result, valid pulse and flags
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      cnt        <= '0;
      p          <= '0;
      a_r        <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
`ifdef ALU_DIV_EN
      b_r        <= '0;
      flag_dz    <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            if (select == 4'd4) begin
              state <= MUL;
              a_r   <= A;
              p     <= zx(B);
            end
`ifdef ALU_DIV_EN
            else if (select == 4'd0) begin
              state <= DIV;
              b_r   <= B;
              p     <= zx(A);
            end
`endif
            else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out        <= alu_res;
              flag_zero  <= (alu_res == '0);
              flag_carry <= alu_carry;
`ifdef ALU_DIV_EN
              flag_dz    <= 1'b0;
`endif
            end
          end
        end
        MUL: begin
          p   <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out        <= mul_next;
            flag_zero  <= (mul_next == '0);
            flag_carry <= 1'b0;
`ifdef ALU_DIV_EN
            flag_dz    <= 1'b0;
`endif
          end
        end
`ifdef ALU_DIV_EN
        DIV: begin
          p   <= div_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out        <= div_next;
            flag_zero  <= (div_next == '0);
            flag_carry <= 1'b0;
            flag_dz    <= (b_r == '0);
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed bench for alu_seq_core at WIDTH=8 and WIDTH=2.
// Arithmetic model + per-cycle scoreboard, plus literal spot values.
module tb_alu_seq_core;

  logic clk = 1'b0;
  logic res = 1'b1;

  logic       iv [2];
  logic [7:0] av [2];
  logic [7:0] bv [2];
  logic [3:0] sv [2];

  logic        rdy8, ov8, fz8, fc8, fd8;
  logic [15:0] o8;
  logic        rdy2, ov2, fz2, fc2, fd2;
  logic [3:0]  o2;

  logic        rdy [2];
  logic        ov  [2];
  logic        fz  [2];
  logic        fc  [2];
  logic        fd  [2];
  logic [15:0] o   [2];

  alu_seq_core #(.WIDTH(8)) u8 (
    .clk(clk), .res(res), .in_valid(iv[0]), .in_ready(rdy8),
    .A(av[0]), .B(bv[0]), .select(sv[0]), .out_valid(ov8),
    .out(o8), .flag_zero(fz8), .flag_carry(fc8), .flag_dz(fd8)
  );

  alu_seq_core #(.WIDTH(2)) u2 (
    .clk(clk), .res(res), .in_valid(iv[1]), .in_ready(rdy2),
    .A(av[1][1:0]), .B(bv[1][1:0]), .select(sv[1]), .out_valid(ov2),
    .out(o2), .flag_zero(fz2), .flag_carry(fc2), .flag_dz(fd2)
  );

  assign rdy[0] = rdy8;
  assign ov[0]  = ov8;
  assign fz[0]  = fz8;
  assign fc[0]  = fc8;
  assign fd[0]  = fd8;
  assign o[0]   = o8;
  assign rdy[1] = rdy2;
  assign ov[1]  = ov2;
  assign fz[1]  = fz2;
  assign fc[1]  = fc2;
  assign fd[1]  = fd2;
  assign o[1]   = {12'd0, o2};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int u,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d t=%0t got %0h want %0h",
               name, u, $time, act, exp);
    end
  endtask

  function automatic void model(input int op, input longint a,
                                input longint b, input int w,
                                output longint r, output bit c,
                                output bit z, output bit d,
                                output int lat);
    longint m;
    m = (longint'(1) << w) - 1;
    r = 0; c = 0; d = 0; lat = 1;
    case (op)
      0: begin
`ifdef ALU_DIV_EN
        lat = w + 1;
        if (b == 0) begin
          r = (a << w) | m;
          d = 1;
        end else begin
          r = ((a % b) << w) | (a / b);
        end
`else
        r = a + b;
        c = ((a + b) >> w) != 0;
`endif
      end
      1: begin r = a + b; c = ((a + b) >> w) != 0; end
      2: begin r = (a - b) & m; c = a < b; end
      3: begin r = (b - a) & m; c = b < a; end
      4: begin r = a * b; lat = w + 1; end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = a >> 1;
      9: r = (a << 1) & m;
      10: r = b >> 1;
      11: r = (b << 1) & m;
      12: r = (a >> 1) | (a & (longint'(1) << (w - 1)));
      13: r = (b >> 1) | (b & (longint'(1) << (w - 1)));
      14: r = (a == b) ? 1 : 0;
      15: r = (a > b) ? 1 : 0;
      default: r = 0;
    endcase
    z = (r == 0);
  endfunction

  // scoreboard: at most one op in flight per unit
  bit     pend [2];
  int     due  [2];
  longint eo   [2];
  bit     ec   [2];
  bit     ez   [2];
  bit     ed   [2];
  longint lo   [2];
  bit     lc   [2];
  bit     lz   [2];
  bit     ld   [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin : cmp
      int     w;
      int     ml;
      bit     acc;
      bit     ev;
      bit     mc, mz, md;
      longint mo;
      longint msk;
      w   = (u == 0) ? 8 : 2;
      msk = (longint'(1) << w) - 1;
      if (res) begin
        pend[u] = 0;
        lo[u] = 0; lc[u] = 0; lz[u] = 0; ld[u] = 0;
      end else begin
        acc = iv[u] && !pend[u];
        chk("in_ready", u, rdy[u], !pend[u]);
        ev = pend[u] && (due[u] == cyc);
        chk("out_valid", u, ov[u], ev);
        if (ev) begin
          lo[u] = eo[u]; lc[u] = ec[u];
          lz[u] = ez[u]; ld[u] = ed[u];
          pend[u] = 0;
        end
        chk("out", u, o[u], lo[u]);
        chk("flag_zero", u, fz[u], lz[u]);
        chk("flag_carry", u, fc[u], lc[u]);
        chk("flag_dz", u, fd[u], ld[u]);
        if (acc) begin
          model(int'(sv[u]), longint'(av[u]) & msk,
                longint'(bv[u]) & msk, w, mo, mc, mz, md, ml);
          pend[u] = 1;
          due[u]  = cyc + ml;
          eo[u] = mo; ec[u] = mc; ez[u] = mz; ed[u] = md;
        end
      end
    end
  end

  task automatic send(input int u, input int op, input int a, input int b);
    int n;
    n = 0;
    while (!rdy[u] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[u]) chk("send_timeout", u, rdy[u], 1);
    iv[u] = 1'b1;
    sv[u] = 4'(op);
    av[u] = 8'(a);
    bv[u] = 8'(b);
    @(posedge clk); #1;
    iv[u] = 1'b0;
  endtask

  task automatic wait_out(input int u, output int lat);
    int n;
    n = 0;
    while (!ov[u] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_timeout", u, ov[u], 1);
    lat = n + 1;
  endtask

  task automatic do_op(input int u, input int op, input int a,
                       input int b, output int lat);
    send(u, op, a, b);
    wait_out(u, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  int pa [7] = '{0, 255, 170, 128, 7, 255, 1};
  int pb [7] = '{0, 1, 85, 127, 200, 255, 0};

  initial begin
    int lat;
    int n;
    bit r;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; av[u] = '0; bv[u] = '0; sv[u] = '0;
    end
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 0, rdy[0], 1);
    chk("rst_out", 0, o[0], 0);
    chk("rst_valid", 0, ov[0], 0);

    do_op(0, 1, 200, 100, lat);
    chk("add_lat", 0, lat, 1);
    chk("add_out", 0, o[0], 300);
    chk("add_c", 0, fc[0], 1);

    do_op(0, 2, 5, 7, lat);
    chk("sub_out", 0, o[0], 254);
    chk("sub_c", 0, fc[0], 1);

    do_op(0, 4, 255, 255, lat);
    chk("mul_lat", 0, lat, 9);
    chk("mul_out", 0, o[0], 65025);
    chk("mul_c", 0, fc[0], 0);

    do_op(0, 4, 0, 77, lat);
    chk("mul0_out", 0, o[0], 0);
    chk("mul0_z", 0, fz[0], 1);

    do_op(0, 12, 8'h90, 0, lat);
    chk("asr_a", 0, o[0], 16'h00C8);
    do_op(0, 13, 0, 8'h40, lat);
    chk("asr_b", 0, o[0], 16'h0020);
    do_op(0, 15, 3, 3, lat);
    chk("gt_out", 0, o[0], 0);
    chk("gt_z", 0, fz[0], 1);

`ifdef ALU_DIV_EN
    do_op(0, 0, 100, 7, lat);
    chk("div_lat", 0, lat, 9);
    chk("div_out", 0, o[0], 16'h020E);
    chk("div_dz", 0, fd[0], 0);
    do_op(0, 0, 100, 0, lat);
    chk("dz_lat", 0, lat, 9);
    chk("dz_out", 0, o[0], 16'h64FF);
    chk("dz_flag", 0, fd[0], 1);
`else
    do_op(0, 0, 200, 100, lat);
    chk("op0_lat", 0, lat, 1);
    chk("op0_out", 0, o[0], 300);
    chk("op0_dz", 0, fd[0], 0);
`endif

    send(0, 4, 3, 5);
    repeat (3) @(posedge clk);
    #1 res = 1'b1;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    chk("abort_out", 0, o[0], 0);
    chk("abort_ready", 0, rdy[0], 1);
    chk("abort_valid", 0, ov[0], 0);
    chk("abort_z", 0, fz[0], 0);
    chk("abort_c", 0, fc[0], 0);
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov[0]) n++;
    end
    chk("late_pulse", 0, n, 0);

    send(0, 4, 12, 10);
    iv[0] = 1'b1; sv[0] = 4'd1; av[0] = 8'd1; bv[0] = 8'd2;
    n = 0;
    do begin
      r = rdy[0];
      @(posedge clk); #1;
      n++;
    end while (!r && n < 40);
    iv[0] = 1'b0;
    chk("hold_cycles", 0, n, 10);
    wait_out(0, lat);
    chk("hold_out", 0, o[0], 3);

    for (int op = 0; op < 16; op++)
      for (int k = 0; k < 7; k++)
        do_op(0, op, pa[k], pb[k], lat);

    do_op(1, 4, 3, 3, lat);
    chk("w2_mul_lat", 1, lat, 3);
    chk("w2_mul", 1, o[1], 9);
    do_op(1, 12, 2, 0, lat);
    chk("w2_asr", 1, o[1], 3);
    do_op(1, 1, 3, 3, lat);
    chk("w2_add", 1, o[1], 6);
    chk("w2_add_c", 1, fc[1], 1);

    for (int op = 0; op < 16; op++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          do_op(1, op, a, b, lat);

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
